// File: rtl/glcd_char_sequencer_pkg.sv
// Shared types and constants for the graphic-LCD character sequencer.
// The display is two 64-column halves with 8 pages each; glyphs are 5 columns wide plus a 1-column spacer.
package glcd_char_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SET_PAGE,
    SET_COL,
    DATA,
    NEXT
  } state_t;

  localparam logic [7:0] CMD_SET_PAGE = 8'hB8;
  localparam logic [7:0] CMD_SET_COL  = 8'h40;

  localparam int GLYPH_W   = 5;
  localparam int CELL_W    = 6;
  localparam int LINE_COLS = 126;
  localparam int HALF_COLS = 64;

  localparam logic [1:0] CS_LEFT  = 2'b01;
  localparam logic [1:0] CS_RIGHT = 2'b10;

  function automatic logic [1:0] half_sel(input logic [6:0] col);
    return (col < 7'(HALF_COLS)) ? CS_LEFT : CS_RIGHT;
  endfunction

  // Glyph columns go out most-significant byte first.
  function automatic logic [7:0] glyph_byte(input logic [39:0] glyph, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = glyph[39:32];
      3'd1:    b = glyph[31:24];
      3'd2:    b = glyph[23:16];
      3'd3:    b = glyph[15:8];
      3'd4:    b = glyph[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/glcd_char_sequencer_cursor.sv
// Text cursor: page 0..7 and pixel column; home is applied before newline/advance in the same cycle.
// wrap qualifies advance so that reaching the end of the line moves to column 0 of the next page.
module glcd_cursor
  import glcd_char_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       home,
  input  logic       advance,
  input  logic       wrap,
  input  logic       newline,
  output logic [2:0] page,
  output logic [6:0] col
);

  logic [2:0] base_page;
  logic [6:0] base_col;
  logic [2:0] page_d;
  logic [6:0] col_d;

  always_comb begin
    base_page = home ? 3'd0 : page;
    base_col  = home ? 7'd0 : col;
    page_d    = base_page;
    col_d     = base_col;
    if (newline) begin
      col_d  = 7'd0;
      page_d = base_page + 3'd1;
    end else if (advance) begin
      if (wrap && ((base_col + 7'd1) == 7'(LINE_COLS))) begin
        col_d  = 7'd0;
        page_d = base_page + 3'd1;
      end else begin
        col_d = base_col + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      page <= 3'd0;
      col  <= 7'd0;
    end else begin
      page <= page_d;
      col  <= col_d;
    end
  end

endmodule

// File: rtl/glcd_char_sequencer.sv
// Turns ASCII characters into page/column commands plus six data bytes per glyph for a dual-half GLCD.
// The spacer byte is sent from NEXT so the line-wrap decision costs no extra cycle.
module glcd_char_sequencer
  import glcd_char_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  input  logic        home,
  output logic [6:0]  rom_addr,
  input  logic [39:0] rom_data,
  output logic        lcd_valid,
  input  logic        lcd_ready,
  output logic        lcd_rs,
  output logic [1:0]  lcd_cs,
  output logic [7:0]  lcd_data,
  output logic        busy
);

  state_t      state;
  state_t      state_d;
  logic [39:0] glyph;
  logic [2:0]  byte_idx;
  logic [2:0]  page;
  logic [6:0]  col;

  logic accept;
  logic is_print;
  logic is_newline;
  logic cur_home;
  logic cur_advance;
  logic cur_wrap;
  logic cur_newline;
  logic at_half;

  assign char_ready = reset && (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = char_valid && char_ready;
  assign is_print   = !char_data[7] && (char_data[6:5] != 2'b00);
  assign is_newline = (char_data == 8'h0A);
  assign at_half    = ((col + 7'd1) == 7'(HALF_COLS));

  assign cur_home    = (state == IDLE) && home;
  assign cur_newline = accept && is_newline;
  assign cur_advance = lcd_ready && ((state == DATA) || (state == NEXT));
  assign cur_wrap    = (state == NEXT);

  glcd_cursor u_cursor (
    .clk     (clk),
    .reset   (reset),
    .home    (cur_home),
    .advance (cur_advance),
    .wrap    (cur_wrap),
    .newline (cur_newline),
    .page    (page),
    .col     (col)
  );

  always_comb begin
    state_d   = state;
    lcd_valid = 1'b0;
    lcd_rs    = 1'b0;
    lcd_cs    = 2'b00;
    lcd_data  = 8'h00;
    case (state)
      IDLE: begin
        if (accept && is_print) state_d = LOAD;
      end
      LOAD: begin
        state_d = SET_PAGE;
      end
      SET_PAGE: begin
        lcd_valid = 1'b1;
        lcd_cs    = half_sel(col);
        lcd_data  = CMD_SET_PAGE | {5'b0, page};
        if (lcd_ready) state_d = SET_COL;
      end
      SET_COL: begin
        lcd_valid = 1'b1;
        lcd_cs    = half_sel(col);
        lcd_data  = CMD_SET_COL | {2'b0, col[5:0]};
        // Re-addressing after a half crossing may land just before the spacer.
        if (lcd_ready) state_d = (byte_idx == 3'(CELL_W - 1)) ? NEXT : DATA;
      end
      DATA: begin
        lcd_valid = 1'b1;
        lcd_rs    = 1'b1;
        lcd_cs    = half_sel(col);
        lcd_data  = glyph_byte(glyph, byte_idx);
        if (lcd_ready) begin
          if (at_half)                              state_d = SET_PAGE;
          else if (byte_idx == 3'(GLYPH_W - 1))     state_d = NEXT;
          else                                      state_d = DATA;
        end
      end
      NEXT: begin
        lcd_valid = 1'b1;
        lcd_rs    = 1'b1;
        lcd_cs    = half_sel(col);
        lcd_data  = 8'h00;
        if (lcd_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      rom_addr <= 7'd0;
      glyph    <= 40'd0;
      byte_idx <= 3'd0;
    end else begin
      state <= state_d;
      if (accept && is_print) begin
        rom_addr <= char_data[6:0] - 7'h20;
        byte_idx <= 3'd0;
      end
      if (state == LOAD) glyph <= rom_data;
      if ((state == DATA) && lcd_ready) byte_idx <= byte_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_glcd_char_sequencer.sv
// Directed and randomized bench for glcd_char_sequencer against a per-character transfer model.
module tb_glcd_char_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready;
  logic        home = 1'b0;
  logic [6:0]  rom_addr;
  logic [39:0] rom_data;
  logic        lcd_valid;
  logic        lcd_ready = 1'b0;
  logic        lcd_rs;
  logic [1:0]  lcd_cs;
  logic [7:0]  lcd_data;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 never
  int m_page = 0;
  int m_col  = 0;
  logic [10:0] obs_q[$];
  logic [10:0] exp_q[$];

  glcd_char_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .home       (home),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .lcd_valid  (lcd_valid),
    .lcd_ready  (lcd_ready),
    .lcd_rs     (lcd_rs),
    .lcd_cs     (lcd_cs),
    .lcd_data   (lcd_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] font(input logic [6:0] a);
    case (a)
      7'h21:   font = 40'h7E1111117E;
      7'h22:   font = 40'h7F49494936;
      default: font = {1'b1, a, a ^ 7'h55, 1'b0, 1'b0, ~a, a, 1'b1, 8'hC3 ^ {1'b0, a}};
    endcase
  endfunction

  assign rom_data = font(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       lcd_ready = 1'b1;
      1:       lcd_ready = ~lcd_ready;
      2:       lcd_ready = 1'($urandom_range(0, 1));
      default: lcd_ready = 1'b0;
    endcase
  end

  // Transfer capture and stall-stability monitor.
  logic        stall_prev = 1'b0;
  logic [10:0] stall_out  = 11'd0;
  always @(negedge clk) begin
    if (reset && stall_prev)
      chk("stall_stable", 32'({lcd_valid, lcd_rs, lcd_cs, lcd_data}), 32'({1'b1, stall_out}));
    if (reset && lcd_valid && lcd_ready) obs_q.push_back({lcd_rs, lcd_cs, lcd_data});
    stall_prev = reset && lcd_valid && !lcd_ready;
    stall_out  = {lcd_rs, lcd_cs, lcd_data};
  end

  // Reference: cursor as integers, each printable emits its full transfer list.
  task automatic model_char(input logic [7:0] c, input logic h);
    logic [39:0] g;
    logic [1:0]  cs;
    if (h) begin m_page = 0; m_col = 0; end
    if (c == 8'h0A) begin
      m_col  = 0;
      m_page = (m_page + 1) % 8;
    end else if (c >= 8'h20 && c <= 8'h7F) begin
      g  = font(7'(c - 8'h20));
      cs = (m_col < 64) ? 2'b01 : 2'b10;
      exp_q.push_back({1'b0, cs, 8'hB8 | 8'(m_page)});
      exp_q.push_back({1'b0, cs, 8'h40 | 8'(m_col % 64)});
      for (int i = 0; i < 6; i++) begin
        if (i > 0 && m_col == 64) begin
          exp_q.push_back({1'b0, 2'b10, 8'hB8 | 8'(m_page)});
          exp_q.push_back({1'b0, 2'b10, 8'h40});
        end
        cs = (m_col < 64) ? 2'b01 : 2'b10;
        exp_q.push_back({1'b1, cs, (i < 5) ? g[39-8*i -: 8] : 8'h00});
        m_col++;
      end
      if (m_col == 126) begin m_col = 0; m_page = (m_page + 1) % 8; end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!char_ready && n < 300) begin @(negedge clk); n++; end
    chk("ready_timeout", 32'(n < 300), 32'(1));
  endtask

  task automatic accept(input logic [7:0] c, input logic h);
    wait_ready();
    char_valid = 1'b1; char_data = c; home = h;
    @(posedge clk); #1;
    char_valid = 1'b0; home = 1'b0;
    model_char(c, h);
  endtask

  task automatic pulse_home();
    wait_ready();
    home = 1'b1;
    @(posedge clk); #1;
    home = 1'b0;
    m_page = 0; m_col = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || !char_ready) && n < 300) begin @(negedge clk); n++; end
    chk("idle_timeout", 32'(n < 300), 32'(1));
  endtask

  task automatic compare_q(input string tag);
    chk(tag, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) chk(tag, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic send(input logic [7:0] c, input logic h, input string tag);
    accept(c, h);
    wait_idle();
    compare_q(tag);
  endtask

  // 'A' from the current cursor with full-rate ready: fixed latency and ROM index.
  task automatic a_test(input string tag);
    int n = 0;
    accept(8'h41, 1'b0);
    while (n < 50) begin
      @(negedge clk); n++;
      if (n == 1) chk("rom_addr_A", 32'(rom_addr), 32'h21);
      if (char_ready) break;
    end
    chk("latency_A", 32'(n), 32'd10);
    wait_idle();
    compare_q(tag);
  endtask

  initial begin
    logic [7:0] c;
    int n;
    repeat (2) @(negedge clk);
    chk("rst_char_ready", 32'(char_ready), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_lcd_valid",  32'(lcd_valid),  32'd0);
    chk("rst_lcd_rs",     32'(lcd_rs),     32'd0);
    chk("rst_lcd_cs",     32'(lcd_cs),     32'd0);
    chk("rst_lcd_data",   32'(lcd_data),   32'd0);
    chk("rst_rom_addr",   32'(rom_addr),   32'd0);
    reset = 1'b1;

    a_test("xfer_A");

    // Ten spaces then 'B' straddles the half boundary at column 64.
    pulse_home();
    for (int i = 0; i < 10; i++) send(8'h20, 1'b0, "xfer_space");
    send(8'h42, 1'b0, "xfer_B_cross");

    // A full line wraps to the next page.
    rdy_mode = 2;
    pulse_home();
    for (int i = 0; i < 21; i++) send(8'($urandom_range(32, 127)), 1'b0, "xfer_line");
    accept(8'h58, 1'b0);
    wait_idle();
    chk("wrap_page_cmd", 32'(obs_q[0]), 32'h1B9);
    chk("wrap_col_cmd",  32'(obs_q[1]), 32'h140);
    compare_q("xfer_after_wrap");

    // Alternating ready across a half crossing.
    rdy_mode = 1;
    pulse_home();
    for (int i = 0; i < 12; i++) send(8'($urandom_range(32, 127)), 1'b0, "xfer_toggle");

    // Newline wrap from page 7, dropped control code, home with a character.
    rdy_mode = 0;
    pulse_home();
    for (int i = 0; i < 7; i++) send(8'h0A, 1'b0, "newline_quiet");
    send(8'h0A, 1'b0, "newline_p7");
    send(8'h07, 1'b0, "drop_bel");
    send(8'h41, 1'b0, "after_drop");
    pulse_home();
    for (int i = 0; i < 3; i++) send(8'h0A, 1'b0, "newline_quiet");
    for (int i = 0; i < 3; i++) send(8'h30, 1'b0, "xfer_digit");
    accept(8'h21, 1'b1);
    wait_idle();
    chk("home_page_cmd", 32'(obs_q[0]), 32'h1B8);
    chk("home_col_cmd",  32'(obs_q[1]), 32'h140);
    compare_q("xfer_home_bang");

    // Home while busy is ignored.
    accept(8'h43, 1'b0);
    repeat (3) @(negedge clk);
    home = 1'b1;
    @(posedge clk); #1;
    home = 1'b0;
    wait_idle();
    compare_q("xfer_busy_home");
    send(8'h44, 1'b0, "xfer_after_busy_home");

    // Randomized character stream with random backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      n = $urandom_range(0, 9);
      if (n < 6)       c = 8'($urandom_range(32, 127));
      else if (n == 6) c = 8'h0A;
      else             c = 8'($urandom_range(0, 255));
      send(c, 1'($urandom_range(0, 9) == 0), "xfer_random");
    end

    // Reset while the third data byte is stalled.
    rdy_mode = 0;
    pulse_home();
    accept(8'h41, 1'b0);
    for (int i = 1; i <= 5; i++) @(negedge clk);
    rdy_mode = 3;
    @(negedge clk);
    chk("stall_byte3", 32'({lcd_valid, lcd_rs, lcd_ready, lcd_data}), 32'({3'b110, 8'h11}));
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_lcd_valid",  32'(lcd_valid),  32'd0);
    chk("mid_rst_busy",       32'(busy),       32'd0);
    chk("mid_rst_char_ready", 32'(char_ready), 32'd0);
    chk("mid_rst_lcd_cs",     32'(lcd_cs),     32'd0);
    chk("mid_rst_lcd_data",   32'(lcd_data),   32'd0);
    chk("mid_rst_rom_addr",   32'(rom_addr),   32'd0);
    reset = 1'b1;
    rdy_mode = 0;
    obs_q.delete(); exp_q.delete();
    m_page = 0; m_col = 0;
    @(negedge clk);
    chk("ready_after_reset", 32'(char_ready), 32'd1);
    a_test("xfer_A_after_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
